// File: rtl/nfu_pkg.sv
// rtl/nfu_pkg.sv - NFU shared constants, clog2 and output saturation helper
package nfu_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int Tn        = 16;
  localparam int TnxTn     = Tn * Tn;
  localparam int ACC_WIDTH = 32;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Full-growth width of one row sum.
  localparam int TREE_WIDTH = BIT_WIDTH + clog2(Tn);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (BIT_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

  // Clamp an accumulator to the signed BIT_WIDTH range.
  function automatic logic [BIT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX) return SAT_MAX[BIT_WIDTH-1:0];
    if (a < SAT_MIN) return SAT_MIN[BIT_WIDTH-1:0];
    return a[BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/nfu_2_adder_tree.sv
// rtl/nfu_2_adder_tree.sv - two-stage pipelined full-growth adder tree for one neuron row
module nfu_2_adder_tree
  import nfu_pkg::*;
(
  input  logic                         clk,
  input  logic [BIT_WIDTH*Tn-1:0]      rowProducts,
  output logic signed [TREE_WIDTH-1:0] rowSum
);

  // First stage covers tree levels 1-2 (or all levels when Tn is 2).
  localparam int LOG = clog2(Tn);
  localparam int L1  = (LOG < 2) ? LOG : 2;
  localparam int G   = 1 << L1;
  localparam int N1  = Tn >> L1;

  logic signed [TREE_WIDTH-1:0] groupSum [N1];
  logic signed [TREE_WIDTH-1:0] groupQ   [N1];
  logic signed [TREE_WIDTH-1:0] totalSum;

  // Sum each group of G sign-extended products.
  always_comb begin
    for (int i = 0; i < N1; i++) begin
      groupSum[i] = '0;
      for (int j = 0; j < G; j++) begin
        groupSum[i] = groupSum[i]
                    + TREE_WIDTH'(signed'(rowProducts[(i*G+j)*BIT_WIDTH +: BIT_WIDTH]));
      end
    end
  end

  // First pipe register: partial sums after the early tree levels.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N1; i++) groupQ[i] <= groupSum[i];
  end

  // Remaining tree levels reduce the registered group sums.
  always_comb begin
    totalSum = '0;
    for (int i = 0; i < N1; i++) totalSum = totalSum + groupQ[i];
  end

  // Second pipe register: complete row sum.
  always_ff @(posedge clk) begin
    rowSum <= totalSum;
  end

endmodule

// File: rtl/nfu_2_reduce.sv
// rtl/nfu_2_reduce.sv - NFU-2 row reduction, group accumulation, saturation and 2-entry output queue
module nfu_2_reduce
  import nfu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [BIT_WIDTH*TnxTn-1:0] i_products,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [BIT_WIDTH*Tn-1:0]  o_sums,
  output logic                     o_last_ok,
  output logic                     o_overflow
);

  logic signed [TREE_WIDTH-1:0] treeSum [Tn];
  logic signed [ACC_WIDTH-1:0]  acc     [Tn];

  // Control travelling alongside the tree data; first/last qualified by valid.
  logic validQ1, firstQ1, lastQ1;
  logic validQ2, firstQ2, lastQ2;
  logic pushQ3;

  logic [BIT_WIDTH*Tn-1:0] fifoMem [2];
  logic                    wrPtr, rdPtr;
  logic [1:0]              count;
  logic [BIT_WIDTH*Tn-1:0] satVec;
  logic                    doPush, doPop;
  logic [2:0]              outstanding;

  for (genvar n = 0; n < Tn; n++) begin : gTree
    nfu_2_adder_tree uTree (
      .clk        (clk),
      .rowProducts(i_products[n*Tn*BIT_WIDTH +: Tn*BIT_WIDTH]),
      .rowSum     (treeSum[n])
    );
  end

  // Move tile flags down the pipe in step with the tree stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validQ1 <= 1'b0; firstQ1 <= 1'b0; lastQ1 <= 1'b0;
      validQ2 <= 1'b0; firstQ2 <= 1'b0; lastQ2 <= 1'b0;
      pushQ3  <= 1'b0;
    end else begin
      validQ1 <= i_valid;
      firstQ1 <= i_valid & i_first;
      lastQ1  <= i_valid & i_last;
      validQ2 <= validQ1;
      firstQ2 <= firstQ1;
      lastQ2  <= lastQ1;
      pushQ3  <= lastQ2;
    end
  end

  // Per-neuron accumulator: restart on first tile, wrap-add otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < Tn; n++) acc[n] <= '0;
    end else if (validQ2) begin
      for (int n = 0; n < Tn; n++) begin
        if (firstQ2) acc[n] <= ACC_WIDTH'(treeSum[n]);
        else         acc[n] <= acc[n] + ACC_WIDTH'(treeSum[n]);
      end
    end
  end

  // Saturated view of the finished group, written the cycle after the last tile lands.
  always_comb begin
    satVec = '0;
    for (int n = 0; n < Tn; n++) satVec[n*BIT_WIDTH +: BIT_WIDTH] = saturate(acc[n]);
  end

  assign o_valid = (count != 2'd0);
  assign doPop   = o_valid & i_ready;
  assign doPush  = pushQ3 & ((count != 2'd2) | doPop);
  assign o_sums  = o_valid ? fifoMem[rdPtr] : '0;

  // Credits cover queued results plus last tiles already past the input register.
  assign outstanding = 3'(count) + 3'(lastQ1) + 3'(lastQ2) + 3'(pushQ3);
  assign o_last_ok   = (outstanding < 3'd2);

  // Queue storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= satVec;
  end

  // Queue pointers, occupancy and sticky overflow on a dropped push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      count      <= 2'd0;
      o_overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      count <= count + 2'(doPush) - 2'(doPop);
      if (pushQ3 && !doPush) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nfu_2_reduce.sv
// tb/tb_nfu_2_reduce.sv - self-checking bench for nfu_2_reduce against a behavioural model
module tb_nfu_2_reduce;
  import nfu_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       i_valid;
  logic [BIT_WIDTH*TnxTn-1:0] i_products;
  logic                       i_first;
  logic                       i_last;
  logic                       i_ready;
  logic                       o_valid;
  logic [BIT_WIDTH*Tn-1:0]    o_sums;
  logic                       o_last_ok;
  logic                       o_overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0]  prod [256];
  int           macc [16];
  logic [255:0] expQ [$];
  bit           streamOn = 1'b0;

  nfu_2_reduce dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_products(i_products),
    .i_first   (i_first),
    .i_last    (i_last),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_sums    (o_sums),
    .o_last_ok (o_last_ok),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] splat(input logic [15:0] v);
    logic [255:0] r;
    for (int n = 0; n < 16; n++) r[n*16 +: 16] = v;
    return r;
  endfunction

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (streamOn) begin
      if (o_valid && i_ready) begin
        chk("stream_expected_present", (expQ.size() != 0), 1'b1);
        if (expQ.size() != 0) chk("stream_sums", o_sums, expQ.pop_front());
      end else if (!o_valid) begin
        chk("stream_idle_zero", o_sums, '0);
      end
    end
  endtask

  // Behavioural model: row sum, group accumulation, saturation on last.
  task automatic modelTile(input bit first, input bit last);
    logic [255:0] v;
    int s;
    for (int n = 0; n < 16; n++) begin
      s = 0;
      for (int k = 0; k < 16; k++) s += int'($signed(prod[n*16+k]));
      if (first) macc[n] = s;
      else       macc[n] = macc[n] + s;
      if (macc[n] > 32767)       v[n*16 +: 16] = 16'h7FFF;
      else if (macc[n] < -32768) v[n*16 +: 16] = 16'h8000;
      else                       v[n*16 +: 16] = macc[n][15:0];
    end
    if (last) expQ.push_back(v);
  endtask

  task automatic issue(input bit first, input bit last);
    for (int j = 0; j < 256; j++) i_products[j*16 +: 16] = prod[j];
    i_valid = 1'b1;
    i_first = first;
    i_last  = last;
    modelTile(first, last);
    cyc();
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic fillAll(input logic [15:0] v);
    for (int j = 0; j < 256; j++) prod[j] = v;
  endtask

  // Called right after a last tile: output must appear in cycle 4 for one cycle.
  task automatic expectOut(input string tag, input logic [255:0] direct);
    logic [255:0] e;
    chk({tag, "_early1"}, o_valid, 1'b0);
    cyc(); chk({tag, "_early2"}, o_valid, 1'b0);
    cyc(); chk({tag, "_early3"}, o_valid, 1'b0);
    cyc(); chk({tag, "_valid"}, o_valid, 1'b1);
    e = (expQ.size() != 0) ? expQ.pop_front() : '0;
    chk({tag, "_model"}, o_sums, e);
    chk({tag, "_direct"}, o_sums, direct);
    cyc(); chk({tag, "_once"}, o_valid, 1'b0);
    chk({tag, "_zero"}, o_sums, '0);
  endtask

  initial begin
    logic [255:0] rowVec;
    int w;
    int len;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'($urandom); i_first = 1'($urandom); i_last = 1'($urandom);
      i_ready = 1'($urandom);
      for (int j = 0; j < 256; j++) i_products[j*16 +: 16] = 16'($urandom);
      cyc();
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_sums", o_sums, '0);
      chk("rst_last_ok", o_last_ok, 1'b1);
      chk("rst_overflow", o_overflow, 1'b0);
    end
    for (int n = 0; n < 16; n++) macc[n] = 0;
    rst_n = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("post_rst_no_valid", o_valid, 1'b0);
    end

    // Single tile: row i all = i+1 -> 16*(i+1)
    for (int n = 0; n < 16; n++)
      for (int k = 0; k < 16; k++) prod[n*16+k] = 16'(n + 1);
    for (int n = 0; n < 16; n++) rowVec[n*16 +: 16] = 16'(16 * (n + 1));
    issue(1'b1, 1'b1);
    expectOut("single", rowVec);

    // Multi-tile with bubbles -> 4800
    fillAll(16'd100);
    issue(1'b1, 1'b0);
    cyc(); chk("multi_bubble_a", o_valid, 1'b0);
    cyc(); chk("multi_bubble_b", o_valid, 1'b0);
    issue(1'b0, 1'b0);
    cyc(); chk("multi_bubble_c", o_valid, 1'b0);
    cyc(); chk("multi_bubble_d", o_valid, 1'b0);
    issue(1'b0, 1'b1);
    expectOut("multi", splat(16'd4800));

    // Saturation
    fillAll(16'h7FFF);
    issue(1'b1, 1'b1);
    expectOut("sat_pos", splat(16'h7FFF));
    fillAll(16'h8000);
    issue(1'b1, 1'b1);
    expectOut("sat_neg", splat(16'h8000));
    for (int j = 0; j < 256; j++) prod[j] = ((j % 16) < 8) ? 16'd300 : -16'sd300;
    issue(1'b1, 1'b1);
    expectOut("sat_cancel", splat(16'h0000));

    // Backpressure, credits and overflow
    i_ready = 1'b0;
    fillAll(16'd1);
    issue(1'b1, 1'b1);
    chk("bp_credit_after_one", o_last_ok, 1'b1);
    fillAll(16'd2);
    issue(1'b1, 1'b1);
    chk("bp_credit_after_two", o_last_ok, 1'b0);
    fillAll(16'd3);
    issue(1'b1, 1'b1);
    chk("bp_no_overflow_yet", o_overflow, 1'b0);
    for (int c = 0; c < 5; c++) cyc();
    chk("bp_overflow", o_overflow, 1'b1);
    chk("bp_full_valid", o_valid, 1'b1);
    chk("bp_full_credit", o_last_ok, 1'b0);
    chk("bp_head_16", o_sums, splat(16'd16));
    i_ready = 1'b1;
    cyc();
    chk("bp_second_valid", o_valid, 1'b1);
    chk("bp_head_32", o_sums, splat(16'd32));
    cyc();
    chk("bp_drained", o_valid, 1'b0);
    chk("bp_drained_zero", o_sums, '0);
    chk("bp_credit_back", o_last_ok, 1'b1);
    chk("bp_overflow_sticky", o_overflow, 1'b1);
    expQ.delete();

    // Reset mid-group, then a fresh tile of all-1s
    for (int j = 0; j < 256; j++) prod[j] = 16'($urandom);
    issue(1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    expQ.delete();
    for (int n = 0; n < 16; n++) macc[n] = 0;
    chk("midrst_overflow_cleared", o_overflow, 1'b0);
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_last_ok", o_last_ok, 1'b1);
    fillAll(16'd1);
    issue(1'b1, 1'b1);
    expectOut("midrst_fresh", splat(16'd16));

    // Random groups, back-to-back, streamed against the model
    streamOn = 1'b1;
    for (int g = 0; g < 25; g++) begin
      len = $urandom_range(1, 4);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 1) == 0) begin
          for (int j = 0; j < 256; j++) prod[j] = 16'($urandom);
        end else begin
          for (int j = 0; j < 256; j++) prod[j] = 16'($urandom_range(0, 100)) - 16'd50;
        end
        if (t == len - 1) begin
          w = 0;
          while (!o_last_ok && w < 20) begin
            cyc();
            w++;
          end
          chk("rand_credit_wait", (w < 20), 1'b1);
        end
        issue(t == 0, t == len - 1);
        if ($urandom_range(0, 3) == 0) cyc();
      end
    end
    for (int c = 0; c < 10; c++) cyc();
    chk("rand_all_drained", expQ.size(), 0);
    chk("rand_no_overflow", o_overflow, 1'b0);
    streamOn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nfu_2_reduce.md
# nfu_2_reduce

NFU-2 stage of the neural functional unit. It consumes the Tn×Tn product matrix that NFU-1 emits each cycle and reduces each row of Tn products to one partial sum per output neuron with a pipelined adder tree. Across a group of input tiles it accumulates those sums, then saturates and hands a Tn-wide result vector to NFU-3 through a 2-entry output queue with valid/ready. NFU-1 cannot stall, so the block throttles only at group boundaries, via a credit signal to the controller.

## Interface
- BIT_WIDTH, 16, width of each product and each output sum, two's complement
- Tn, 16, neurons per tile and products per neuron; power of two, ≥2
- TnxTn, 256, Tn*Tn
- ACC_WIDTH, 32, accumulator width; must be ≥ BIT_WIDTH+clog2(Tn)
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- i_valid  in  1  i_products/i_first/i_last valid this cycle
- i_products  in  BIT_WIDTH*TnxTn  row-major; row i (bits (i+1)*Tn*BIT_WIDTH-1 : i*Tn*BIT_WIDTH) = Tn products for neuron i
- i_first  in  1  first tile of a group; ignored unless i_valid
- i_last  in  1  last tile of a group; ignored unless i_valid
- i_ready  in  1  NFU-3 accepts o_sums this cycle
- o_valid  out  1  o_sums holds the queue head
- o_sums  out  BIT_WIDTH*Tn  neuron i at bits (i+1)*BIT_WIDTH-1 : i*BIT_WIDTH
- o_last_ok  out  1  controller may issue an i_last tile this cycle
- o_overflow  out  1  sticky: a result was dropped

## Operation
- Tree: each row is summed at full growth; the tree output is BIT_WIDTH+clog2(Tn) bits and is sign-extended to ACC_WIDTH.
- Accumulate, per accepted tile:
  - i_first=1: acc[i] = tree[i], discarding the old value.
  - i_first=0: acc[i] += tree[i]; ACC_WIDTH wraps with no saturation.
  - i_first=1 together with i_last=1 is a legal single-tile group.
- Bubbles: i_valid=0 inserts a bubble; acc is unchanged. i_first/i_last travel down the pipeline alongside valid.
- Finish: on a last tile, each acc[i] is saturated to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1] and pushed as one entry into a 2-deep FIFO.
- Credits: outstanding = FIFO occupancy + last tiles still in flight. o_last_ok = (outstanding < 2).
- Overflow: a push into a full FIFO with no same-cycle pop discards the new entry and sets o_overflow. It clears only on reset.
- Output handshake: a pop occurs when o_valid && i_ready. A push and a pop in the same cycle are both honoured, including when the FIFO is full. o_sums = 0 whenever o_valid = 0.
- Reset values: o_valid=0, o_sums=0, o_last_ok=1, o_overflow=0; acc=0, FIFO empty, all pipeline valids 0.
- Reset mid-operation discards all in-flight tiles and queued results.

## Timing
Pipeline registers for a tile sampled in cycle 0:
- end of cycle 0: tree levels 1–2 registered
- end of cycle 1: tree levels 3..clog2(Tn) registered
- end of cycle 2: acc updated
- end of cycle 3: saturated result written to FIFO

Consequences:
- A last tile in cycle 0 gives o_valid=1 in cycle 4 if the FIFO was empty.
- Throughput is one tile per cycle, back-to-back, with no bubbles required between groups.
- o_last_ok counts an in-flight last tile from the cycle after it is sampled; the controller samples o_last_ok in the same cycle it asserts i_last.
- FIFO order is strict issue order.

## Structure
- Package nfu_pkg holds:
  - constants BIT_WIDTH, Tn, TnxTn, ACC_WIDTH
  - a clog2 function
  - a saturate(acc) → BIT_WIDTH function
- Sub-module nfu_2_adder_tree: one row of Tn products, 2 internal pipe registers, instantiated Tn times by a generate loop.
- Accumulator, credit counter and FIFO live inline in nfu_2_reduce.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → o_valid=0, o_sums=0, o_last_ok=1, o_overflow=0; release → no spurious o_valid.
- Single tile: row i products all = i+1, i_first=i_last=1, i_ready=1 → o_valid for exactly 1 cycle, in cycle 4; neuron i = 16*(i+1).
- Multi-tile: 3 tiles of all-100 products with 2 bubble cycles between tiles, first on tile 0, last on tile 2 → every neuron = 4800; no output before the last tile + 4 cycles.
- Saturation: all products 0x7FFF → 0x7FFF; all 0x8000 → 0x8000; half +300 and half -300 → 0x0000.
- Backpressure:
  - With i_ready=0, issue 2 single-tile groups (values 1 and 2) → o_last_ok=0 from the cycle after the second.
  - Issue a third group anyway → o_overflow=1.
  - Raise i_ready → values 16 then 32 pop in order, then o_valid=0.
- Reset mid-group: assert rst_n=0 between tile 1 and tile 2 of a group, then run a fresh single tile of all-1s → output 16 in every neuron, with no residue from the aborted group.
